// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles every non-clock signal of the write-back arbiter.
//   Port summary (slave = arbiter side):
//     req0_valid/addr/data -> , req0_ready <-   ALU write-back handshake
//     req1_valid/addr/data -> , req1_ready <-   multi-cycle unit write-back handshake
//     wr_en/wr_addr/wr_data <-                  registered register-file write port
//     issue_en/issue_addr/flush ->              pending-write scoreboard control
//     rs1_addr/rs2_addr -> , rs1_busy/rs2_busy <- decode operand hazard query
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif
`ifndef REGFILE_SIZE
`define REGFILE_SIZE 32
`endif

interface regfile_wb_arbiter_if #(
    parameter int DATA_W = `DATA_SIZE,
    parameter int ADDR_W = `REGFILE_LOGSIZE
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              flush;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data,
        input  issue_en, issue_addr, flush, rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data,
        output issue_en, issue_addr, flush, rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter sharing the register file's single write port between
//   the ALU (req0) and the multi-cycle unit (req1), with registered wr_* outputs.
//   Optional pending-write scoreboard enabled by the macro SCOREBOARD_EN;
//   without it rs1_busy/rs2_busy are tied low and issue/flush are ignored.
//   Ports:
//     clk   rising-edge system clock
//     nrst  asynchronous active-low reset
//     bus   regfile_wb_arbiter_if.slave (handshakes, write port, scoreboard)
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif
`ifndef REGFILE_SIZE
`define REGFILE_SIZE 32
`endif

module regfile_wb_arbiter #(
    parameter int DATA_W = `DATA_SIZE,
    parameter int ADDR_W = `REGFILE_LOGSIZE,
    parameter int NREGS  = `REGFILE_SIZE
) (
    input  logic                 clk,
    input  logic                 nrst,
    regfile_wb_arbiter_if.slave  bus
);

    logic              lastGnt_q, lastGnt_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    // Grant: a lone requester wins; under contention the source that was not
    // granted last wins. x0 writes are consumed but never enable the port.
    always_comb begin
        gnt0      = bus.req0_valid && (!bus.req1_valid || lastGnt_q);
        gnt1      = bus.req1_valid && (!bus.req0_valid || !lastGnt_q);
        selAddr   = gnt1 ? bus.req1_addr : bus.req0_addr;
        selData   = gnt1 ? bus.req1_data : bus.req0_data;
        lastGnt_d = (gnt0 || gnt1) ? gnt1 : lastGnt_q;
        wrEn_d    = (gnt0 || gnt1) && (selAddr != '0);
        wrAddr_d  = wrEn_d ? selAddr : wrAddr_q;
        wrData_d  = wrEn_d ? selData : wrData_q;
    end

    // last_gnt resets to 1 so req0 wins the first contention.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lastGnt_q <= 1'b1;
            wrEn_q    <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
        end else begin
            lastGnt_q <= lastGnt_d;
            wrEn_q    <= wrEn_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.wr_en      = wrEn_q;
    assign bus.wr_addr    = wrAddr_q;
    assign bus.wr_data    = wrData_q;

`ifdef SCOREBOARD_EN
    logic [NREGS-1:1] busy_q, busy_d;
    logic             rs1Busy, rs2Busy;

    // Set is applied after clear so a newer producer wins; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (wrEn_q && wrAddr_q == ADDR_W'(i))
                busy_d[i] = 1'b0;
            if (bus.issue_en && bus.issue_addr == ADDR_W'(i))
                busy_d[i] = 1'b1;
        end
        if (bus.flush)
            busy_d = '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    // A write being presented this cycle is visible through the register-file
    // bypass, so its destination no longer counts as busy.
    always_comb begin
        rs1Busy = 1'b0;
        rs2Busy = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (bus.rs1_addr == ADDR_W'(i) && busy_q[i])
                rs1Busy = 1'b1;
            if (bus.rs2_addr == ADDR_W'(i) && busy_q[i])
                rs2Busy = 1'b1;
        end
        rs1Busy = rs1Busy && !(wrEn_q && wrAddr_q == bus.rs1_addr);
        rs2Busy = rs2Busy && !(wrEn_q && wrAddr_q == bus.rs2_addr);
    end

    assign bus.rs1_busy = rs1Busy;
    assign bus.rs2_busy = rs2Busy;
`else
    wire unusedScoreboard = &{1'b0, bus.issue_en, bus.issue_addr, bus.flush,
                              bus.rs1_addr, bus.rs2_addr};

    assign bus.rs1_busy = 1'b0;
    assign bus.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed self-checking bench for regfile_wb_arbiter: reset values, single
//   requests, round-robin contention, x0 requests, mid-operation reset and,
//   when SCOREBOARD_EN is defined, the pending-write scoreboard.
module tb_regfile_wb_arbiter;

    logic clk;
    logic nrst;
    int   assertCount;
    int   failCount;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives both write-back request channels in one call.
    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    // One comparison point: counts it and reports a failure with $error.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    logic [4:0]  expAddr [4];
    logic [31:0] expData [4];

    initial begin
        assertCount    = 0;
        failCount      = 0;
        expAddr        = '{5'd3, 5'd4, 5'd3, 5'd4};
        expData        = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
        nrst           = 1'b0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.flush      = 1'b0;
        bus.rs1_addr   = '0;
        bus.rs2_addr   = '0;
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset state
        #2;
        checkOutput("reset_wr_en",   bus.wr_en,   0);
        checkOutput("reset_wr_addr", bus.wr_addr, 0);
        checkOutput("reset_wr_data", bus.wr_data, 0);
        checkOutput("reset_ready0",  bus.req0_ready, 0);
        checkOutput("reset_ready1",  bus.req1_ready, 0);
        @(negedge clk);
        nrst = 1'b1;

        // Single req0 write
        @(negedge clk);
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
        #1;
        checkOutput("single_ready0", bus.req0_ready, 1);
        checkOutput("single_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("single_wr_en",   bus.wr_en,   1);
        checkOutput("single_wr_addr", bus.wr_addr, 5);
        checkOutput("single_wr_data", bus.wr_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        checkOutput("single_wr_en_off",  bus.wr_en,   0);
        checkOutput("single_addr_hold",  bus.wr_addr, 5);
        checkOutput("single_data_hold",  bus.wr_data, 32'hDEADBEEF);

        // Fresh reset, then continuous contention
        nrst = 1'b0;
        #2;
        checkOutput("rereset_wr_addr", bus.wr_addr, 0);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1, 3, 32'hA0, 1, 4, 32'hB0);
            #1;
            checkOutput("rr_ready0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            checkOutput("rr_ready1", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
            @(posedge clk); #1;
            checkOutput("rr_wr_en",   bus.wr_en,   1);
            checkOutput("rr_wr_addr", bus.wr_addr, expAddr[i]);
            checkOutput("rr_wr_data", bus.wr_data, expData[i]);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("idle_ready0", bus.req0_ready, 0);
        checkOutput("idle_ready1", bus.req1_ready, 0);

        // req0 alone leaves last_gnt=0, then an x0 request from req1
        @(negedge clk);
        applyStimulus(1, 6, 32'h66, 0, 0, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("pre_x0_wr_addr", bus.wr_addr, 6);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 0, 32'h1234);
        #1;
        checkOutput("x0_ready1", bus.req1_ready, 1);
        checkOutput("x0_ready0", bus.req0_ready, 0);
        @(posedge clk); #1;
        checkOutput("x0_wr_en", bus.wr_en, 0);
        // x0 grant must have moved last_gnt to 1, so req0 wins now
        applyStimulus(1, 3, 32'h33, 1, 4, 32'h44);
        #1;
        checkOutput("post_x0_ready0", bus.req0_ready, 1);
        checkOutput("post_x0_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        checkOutput("post_x0_wr_addr", bus.wr_addr, 3);
        checkOutput("post_x0_ready1b", bus.req1_ready, 1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post_x0_wr_addr2", bus.wr_addr, 4);
        checkOutput("post_x0_wr_data2", bus.wr_data, 32'h44);

        // Reset pulse right after a grant drops the registered write
        @(negedge clk);
        applyStimulus(1, 9, 32'h99, 0, 0, 0);
        @(posedge clk); #1;
        nrst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("midrst_wr_en",   bus.wr_en,   0);
        checkOutput("midrst_wr_addr", bus.wr_addr, 0);
        checkOutput("midrst_wr_data", bus.wr_data, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_wr_en_after", bus.wr_en, 0);
        @(negedge clk);
        applyStimulus(1, 3, 32'h33, 1, 4, 32'h44);
        #1;
        checkOutput("midrst_lastgnt_ready0", bus.req0_ready, 1);
        checkOutput("midrst_lastgnt_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

`ifdef SCOREBOARD_EN
        // Issue 7, then committed by req1 with the bypass masking busy
        @(negedge clk);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        @(posedge clk); #1;
        bus.issue_en   = 1'b0;
        bus.rs1_addr   = 5'd7;
        bus.rs2_addr   = 5'd0;
        #1;
        checkOutput("sb_busy7",     bus.rs1_busy, 1);
        checkOutput("sb_rs2_x0",    bus.rs2_busy, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 7, 32'h77);
        #1;
        checkOutput("sb_wr7_ready1", bus.req1_ready, 1);
        checkOutput("sb_busy7_pre",  bus.rs1_busy, 1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sb_wr7_en",     bus.wr_en, 1);
        checkOutput("sb_bypass7",    bus.rs1_busy, 0);
        @(posedge clk); #1;
        checkOutput("sb_cleared7",   bus.rs1_busy, 0);

        // Same-cycle set and clear of 7: set wins
        @(negedge clk);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        @(posedge clk); #1;
        bus.issue_en   = 1'b0;
        checkOutput("sb_reissue7", bus.rs1_busy, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 7, 32'h78);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        #1;
        checkOutput("sb_setclr_wr_en", bus.wr_en, 1);
        @(posedge clk); #1;
        bus.issue_en   = 1'b0;
        checkOutput("sb_setclr_wins", bus.rs1_busy, 1);

        // Issue 2, 9, 31, then flush together with issue 10
        @(negedge clk);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd2;
        @(negedge clk);
        bus.issue_addr = 5'd9;
        @(negedge clk);
        bus.issue_addr = 5'd31;
        @(negedge clk);
        bus.issue_en   = 1'b0;
        bus.rs1_addr   = 5'd9;
        bus.rs2_addr   = 5'd31;
        #1;
        checkOutput("sb_busy9",  bus.rs1_busy, 1);
        checkOutput("sb_busy31", bus.rs2_busy, 1);
        bus.rs1_addr   = 5'd2;
        #1;
        checkOutput("sb_busy2",  bus.rs1_busy, 1);
        @(negedge clk);
        bus.flush      = 1'b1;
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd10;
        @(posedge clk); #1;
        bus.flush      = 1'b0;
        bus.issue_en   = 1'b0;
        bus.rs1_addr   = 5'd10;
        bus.rs2_addr   = 5'd2;
        #1;
        checkOutput("sb_flush10", bus.rs1_busy, 0);
        checkOutput("sb_flush2",  bus.rs2_busy, 0);
        bus.rs1_addr   = 5'd31;
        bus.rs2_addr   = 5'd7;
        #1;
        checkOutput("sb_flush31", bus.rs1_busy, 0);
        checkOutput("sb_flush7",  bus.rs2_busy, 0);
`else
        // Without the scoreboard, issuing never marks anything busy
        @(negedge clk);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        @(posedge clk); #1;
        bus.issue_en   = 1'b0;
        bus.rs1_addr   = 5'd7;
        bus.rs2_addr   = 5'd7;
        #1;
        checkOutput("nosb_rs1_busy", bus.rs1_busy, 0);
        checkOutput("nosb_rs2_busy", bus.rs2_busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write tracker for the integer register file. Shares the register file's single write port between two write-back sources: req0, the single-cycle ALU pipeline, and req1, the multi-cycle unit (load/mul/div). Sources use a valid/ready handshake and arbitration is round-robin. It drives wr_en/wr_addr/wr_data of reg_file from registered outputs and, optionally, tracks which registers have an in-flight producer.

## Interface
Parameters:
- DATA_W, default `data_size (32): write data width.
- ADDR_W, default `regfile_logsize (5): register address width.
- NREGS, default `regfile_size (32): number of architectural registers.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nrst  in  1  asynchronous reset, active-low.
- req0_valid  in  1  ALU write-back request.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req0_ready  out  1  grant to ALU; transfer when valid && ready.
- req1_valid  in  1  multi-cycle unit write-back request.
- req1_addr  in  ADDR_W  destination register.
- req1_data  in  DATA_W  result.
- req1_ready  out  1  grant to multi-cycle unit.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- issue_en  in  1  decode issues an instruction that writes issue_addr.
- issue_addr  in  ADDR_W  destination of issued instruction.
- flush  in  1  pipeline flush; clears all pending marks.
- rs1_addr, rs2_addr  in  ADDR_W  decode source operands.
- rs1_busy, rs2_busy  out  1  source has an uncommitted producer.

## Operation
- Arbiter state: last_gnt (1 bit, index of last granted source).
- Grant (combinational, same cycle as valid):
  - Only one valid: that source is granted.
  - Both valid: the source != last_gnt is granted.
  - Neither valid: no grant; last_gnt holds.
- last_gnt updates to the granted index on every transfer.
- readyN = 1 only for the granted source; never both in one cycle. Ready never asserts without valid.
- Transfer cycle N: the granted addr/data are registered and presented on wr_* in cycle N+1 with wr_en=1.
- No transfer in cycle N: wr_en=0 in N+1; wr_addr/wr_data hold their previous values.
- Address 0: the request is granted and consumed, but wr_en stays 0 (x0 is never written). It still updates last_gnt.
- Same destination from both sources in one cycle: no merging. The writes are serialized in grant order across two cycles, and the later write wins in the register file.
- Requesters hold addr/data stable while valid && !ready.
- Throughput: one write per cycle. Under continuous contention each source gets every other cycle, so worst-case wait is 1 cycle.

## Timing
- Reset (nrst=0, asynchronous): wr_en=0, wr_addr=0, wr_data=0, last_gnt=1 (req0 wins the first contention), all busy marks cleared. req0_ready/req1_ready follow the grant logic combinationally with the reset state.
- Reset asserted mid-operation: a registered but not yet presented write is dropped.
- Write latency: grant at cycle N, wr_en at cycle N+1. reg_file's same-cycle read bypass covers decode reads in N+1.
- rsX_busy is combinational from busy bits, rsX_addr and the current wr_* outputs.

## Configuration
Macro SCOREBOARD_EN.
- Defined:
  - busy[NREGS-1:1] register.
  - issue_en with issue_addr != 0 sets busy[issue_addr] at the clock edge.
  - wr_en=1 clears busy[wr_addr] at the clock edge.
  - Set and clear of the same register in one cycle: set wins (newer producer).
  - flush=1 clears all bits; a same-cycle issue_en is ignored.
  - rsX_busy = busy[rsX_addr] && !(wr_en && wr_addr == rsX_addr). This accounts for the bypass.
  - rsX_busy = 0 when rsX_addr = 0.
- Not defined: no busy storage; rs1_busy = rs2_busy = 0; issue_en, issue_addr and flush are ignored. All ports remain present.

## Test plan
- Reset, then req0 only (addr=5, data=0xDEADBEEF) -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
- Both valid every cycle for 4 cycles after reset (req0 addr 3 / req1 addr 4) -> grants req0, req1, req0, req1; wr_addr 3, 4, 3, 4 one cycle later.
- req1 valid with addr=0, data=0x1234 -> req1_ready=1, wr_en stays 0, last_gnt=1 (req0 wins the next contention).
- nrst pulsed low for a half cycle right after a grant -> wr_en=0 immediately and stays 0; the dropped write never appears.
- SCOREBOARD_EN: issue_en addr=7 -> rs1_addr=7 gives rs1_busy=1; req1 writes 7 -> rs1_busy=0 in the wr_en cycle. Same-cycle issue_en 7 and wr_en 7 -> busy stays 1.
- SCOREBOARD_EN: issue 2, 9, 31, then flush=1 together with issue_en addr=10 -> all busy=0, including register 10.
